// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Opcodes, datapath width and EX-stage FSM encoding shared across
//               the 16-bit pipelined core.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int c_width_default = 16;

    localparam logic [3:0] c_op_add   = 4'b0000;
    localparam logic [3:0] c_op_sub   = 4'b0001;
    localparam logic [3:0] c_op_and   = 4'b0010;
    localparam logic [3:0] c_op_or    = 4'b0011;
    localparam logic [3:0] c_op_xor   = 4'b0100;
    localparam logic [3:0] c_op_not   = 4'b0101;
    localparam logic [3:0] c_op_shl   = 4'b0110;
    localparam logic [3:0] c_op_shr   = 4'b0111;
    localparam logic [3:0] c_op_mul   = 4'b1000;
    localparam logic [3:0] c_op_load  = 4'b1100;
    localparam logic [3:0] c_op_store = 4'b1110;
    localparam logic [3:0] c_op_nop   = 4'b1111;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_busy = 1'b1;

    // True for opcodes that complete in one cycle and produce a real result.
    function automatic logic is_single_cycle_op(input logic [3:0] op);
        logic r;
        r = 1'b0;
        case (op)
            c_op_add, c_op_sub, c_op_and, c_op_or, c_op_xor, c_op_not,
            c_op_shl, c_op_shr, c_op_load, c_op_store: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Shift-add multiplier, one partial product per cycle; returns
//               the low word of A*B alongside a single-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier
    import core_pkg::*;
#(
    parameter int WIDTH      = c_width_default,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int c_cnt_w = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(MUL_CYCLES - 1);

    logic               r_busy;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_acc;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_acc_next;

    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;

    // The final step's sum is presented combinationally so the caller can
    // register the product on the same edge that retires the last step.
    assign done    = r_busy && (r_count == c_last);
    assign product = w_acc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_count  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_count  <= '0;
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (done) begin
                r_busy  <= 1'b0;
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage
// Description : EX stage - single-cycle ALU, load/store address generation and
//               an iterative multiply that stalls decode while in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage
    import core_pkg::*;
#(
    parameter int WIDTH      = c_width_default,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_id,
    input  logic [3:0]       control_id,
    input  logic [WIDTH-1:0] operand_a_id,
    input  logic [WIDTH-1:0] operand_b_id,
    input  logic [WIDTH-1:0] reg_data_id,
    input  logic [4:0]       dest_reg_index_id,
    input  logic             dest_reg_write_en_id,
    output logic [3:0]       control_ex,
    output logic [WIDTH-1:0] result_ex,
    output logic [WIDTH-1:0] reg_data_ex,
    output logic [4:0]       dest_reg_index_ex,
    output logic             dest_reg_write_en_ex,
    output logic             stall_ex
);

    localparam int c_shw = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [0:0]       r_state;
    logic [4:0]       r_mul_dest_idx;
    logic             r_mul_dest_wen;

    logic             w_is_mul;
    logic             w_mul_start;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;
    logic [WIDTH-1:0] w_alu_result;
    logic [c_shw-1:0] w_shamt;

    logic [0:0]       w_state_next;
    logic [3:0]       w_control_next;
    logic [WIDTH-1:0] w_result_next;
    logic [WIDTH-1:0] w_reg_data_next;
    logic [4:0]       w_dest_idx_next;
    logic             w_dest_wen_next;

    assign w_is_mul    = (control_id == c_op_mul);
    assign w_mul_start = (r_state == c_st_idle) && valid_id && w_is_mul;
    assign w_shamt     = operand_b_id[c_shw-1:0];

    assign stall_ex = w_mul_start || ((r_state == c_st_busy) && !w_mul_done);

    seq_multiplier #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_seq_multiplier (
        .clk     (clk),
        .reset   (reset),
        .start   (w_mul_start),
        .a       (operand_a_id),
        .b       (operand_b_id),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    always_comb begin
        w_alu_result = '0;
        case (control_id)
            c_op_add:   w_alu_result = operand_a_id + operand_b_id;
            c_op_sub:   w_alu_result = operand_a_id + ~operand_b_id + 1'b1;
            c_op_and:   w_alu_result = operand_a_id & operand_b_id;
            c_op_or:    w_alu_result = operand_a_id | operand_b_id;
            c_op_xor:   w_alu_result = operand_a_id ^ operand_b_id;
            c_op_not:   w_alu_result = ~operand_a_id;
            c_op_shl:   w_alu_result = operand_a_id << w_shamt;
            c_op_shr:   w_alu_result = operand_a_id >> w_shamt;
            c_op_load,
            c_op_store: w_alu_result = operand_a_id + operand_b_id;
            default:    w_alu_result = '0;
        endcase
    end

    // Next-state and next-output logic; every path not producing a result
    // falls through to the bubble defaults.
    always_comb begin
        w_state_next    = r_state;
        w_control_next  = c_op_nop;
        w_result_next   = '0;
        w_reg_data_next = '0;
        w_dest_idx_next = '0;
        w_dest_wen_next = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (valid_id) begin
                    if (w_is_mul) begin
                        w_state_next = c_st_busy;
                    end else if (is_single_cycle_op(control_id)) begin
                        w_control_next  = control_id;
                        w_result_next   = w_alu_result;
                        w_reg_data_next = reg_data_id;
                        w_dest_idx_next = dest_reg_index_id;
                        w_dest_wen_next = (control_id == c_op_store) ? 1'b0
                                                                      : dest_reg_write_en_id;
                    end
                end
            end
            c_st_busy: begin
                if (w_mul_done) begin
                    w_state_next    = c_st_idle;
                    w_control_next  = c_op_mul;
                    w_result_next   = w_mul_product;
                    w_dest_idx_next = r_mul_dest_idx;
                    w_dest_wen_next = r_mul_dest_wen;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state              <= c_st_idle;
            r_mul_dest_idx       <= '0;
            r_mul_dest_wen       <= 1'b0;
            control_ex           <= c_op_nop;
            result_ex            <= '0;
            reg_data_ex          <= '0;
            dest_reg_index_ex    <= '0;
            dest_reg_write_en_ex <= 1'b0;
        end else begin
            r_state              <= w_state_next;
            control_ex           <= w_control_next;
            result_ex            <= w_result_next;
            reg_data_ex          <= w_reg_data_next;
            dest_reg_index_ex    <= w_dest_idx_next;
            dest_reg_write_en_ex <= w_dest_wen_next;
            if (w_mul_start) begin
                r_mul_dest_idx <= dest_reg_index_id;
                r_mul_dest_wen <= dest_reg_write_en_id;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_stage
// Description : Directed and randomized checks of execute_stage against a
//               behavioural model of the opcode semantics and MUL timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_id;
    logic [3:0]  control_id;
    logic [15:0] operand_a_id;
    logic [15:0] operand_b_id;
    logic [15:0] reg_data_id;
    logic [4:0]  dest_reg_index_id;
    logic        dest_reg_write_en_id;
    logic [3:0]  control_ex;
    logic [15:0] result_ex;
    logic [15:0] reg_data_ex;
    logic [4:0]  dest_reg_index_ex;
    logic        dest_reg_write_en_ex;
    logic        stall_ex;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    execute_stage #(
        .WIDTH      (16),
        .MUL_CYCLES (16)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .valid_id             (valid_id),
        .control_id           (control_id),
        .operand_a_id         (operand_a_id),
        .operand_b_id         (operand_b_id),
        .reg_data_id          (reg_data_id),
        .dest_reg_index_id    (dest_reg_index_id),
        .dest_reg_write_en_id (dest_reg_write_en_id),
        .control_ex           (control_ex),
        .result_ex            (result_ex),
        .reg_data_ex          (reg_data_ex),
        .dest_reg_index_ex    (dest_reg_index_ex),
        .dest_reg_write_en_ex (dest_reg_write_en_ex),
        .stall_ex             (stall_ex)
    );

    function automatic logic [63:0] pack(input logic [3:0] c, input logic [15:0] r,
                                         input logic [15:0] d, input logic [4:0] i,
                                         input logic w);
        return {22'd0, c, r, d, i, w};
    endfunction

    function automatic logic [63:0] observed();
        return pack(control_ex, result_ex, reg_data_ex, dest_reg_index_ex, dest_reg_write_en_ex);
    endfunction

    function automatic logic [63:0] bubble();
        return pack(4'b1111, 16'd0, 16'd0, 5'd0, 1'b0);
    endfunction

    // Reference semantics written directly from the opcode table.
    function automatic logic [63:0] model(input logic [3:0] op, input int unsigned a,
                                          input int unsigned b, input logic [15:0] rd,
                                          input logic [4:0] idx, input logic wen);
        int unsigned r;
        logic [15:0] r16;
        case (op)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0100: r = a ^ b;
            4'b0101: r = ~a;
            4'b0110: r = a << (b % 16);
            4'b0111: r = a >> (b % 16);
            4'b1100: r = a + b;
            4'b1110: r = a + b;
            default: return bubble();
        endcase
        r16 = r[15:0];
        return pack(op, r16, rd, idx, (op == 4'b1110) ? 1'b0 : wen);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] rd,
                         input logic [4:0] idx, input logic wen);
        valid_id             = v;
        control_id           = op;
        operand_a_id         = a;
        operand_b_id         = b;
        reg_data_id          = rd;
        dest_reg_index_id    = idx;
        dest_reg_write_en_id = wen;
    endtask

    task automatic single(input string tag, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] rd,
                          input logic [4:0] idx, input logic wen);
        drive(1'b1, op, a, b, rd, idx, wen);
        #1;
        chk({tag, "_stall"}, {63'd0, stall_ex}, 64'd0);
        tick();
        chk(tag, observed(), model(op, a, b, rd, idx, wen));
    endtask

    task automatic gap(input string tag);
        drive(1'b0, 4'b0000, 16'h1234, 16'h5678, 16'h9abc, 5'd7, 1'b1);
        #1;
        chk({tag, "_stall"}, {63'd0, stall_ex}, 64'd0);
        tick();
        chk(tag, observed(), bubble());
    endtask

    task automatic mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [4:0] idx, input logic wen);
        int unsigned p;
        logic [15:0] p16;
        p   = a * b;
        p16 = p[15:0];
        drive(1'b1, 4'b1000, a, b, 16'hdead, idx, wen);
        #1;
        chk({tag, "_stall_c0"}, {63'd0, stall_ex}, 64'd1);
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk({tag, "_bubble"}, observed(), bubble());
            chk({tag, "_stall"}, {63'd0, stall_ex}, {63'd0, (c < 16)});
        end
        tick();
        chk({tag, "_product"}, {22'd0, control_ex, result_ex, 16'd0, dest_reg_index_ex,
                                dest_reg_write_en_ex},
            pack(4'b1000, p16, 16'd0, idx, wen));
    endtask

    initial begin
        logic [3:0] ops [12];
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hC, 4'hE, 4'hF, 4'h9};

        reset = 1'b1;
        drive(1'b0, 4'b0000, 16'd0, 16'd0, 16'd0, 5'd0, 1'b0);
        tick();
        tick();
        chk("reset_outputs", observed(), bubble());
        chk("reset_stall", {63'd0, stall_ex}, 64'd0);
        reset = 1'b0;

        single("add_wrap", 4'b0000, 16'hFFFF, 16'h0002, 16'd0, 5'd1, 1'b1);
        chk("add_wrap_value", {48'd0, result_ex}, 64'h0001);
        single("load", 4'b1100, 16'd10, 16'd2, 16'd13, 5'd5, 1'b1);
        chk("load_value", observed(), pack(4'b1100, 16'd12, 16'd13, 5'd5, 1'b1));
        single("store", 4'b1110, 16'd10, 16'd2, 16'd13, 5'd5, 1'b1);
        chk("store_wen", {63'd0, dest_reg_write_en_ex}, 64'd0);
        single("sub", 4'b0001, 16'd3, 16'd5, 16'd0, 5'd2, 1'b1);
        single("shl", 4'b0110, 16'h0001, 16'h0013, 16'd0, 5'd3, 1'b1);

        mul("mul_300x7", 16'd300, 16'd7, 5'd9, 1'b1);
        chk("mul_300x7_value", {48'd0, result_ex}, 64'h0834);
        mul("mul_wrap0", 16'h0100, 16'h0100, 5'd4, 1'b1);
        mul("mul_ffff", 16'hFFFF, 16'hFFFF, 5'd6, 1'b0);
        chk("mul_ffff_value", {48'd0, result_ex}, 64'h0001);

        // Reset lands in BUSY cycle 5.
        drive(1'b1, 4'b1000, 16'd300, 16'd7, 16'd0, 5'd9, 1'b1);
        for (int c = 1; c <= 5; c++) tick();
        reset = 1'b1;
        drive(1'b0, 4'b0000, 16'd0, 16'd0, 16'd0, 5'd0, 1'b0);
        tick();
        reset = 1'b0;
        chk("midmul_reset_out", observed(), bubble());
        chk("midmul_reset_stall", {63'd0, stall_ex}, 64'd0);
        single("add_after_reset", 4'b0000, 16'd3, 16'd4, 16'd0, 5'd1, 1'b1);
        chk("add_after_reset_val", {48'd0, result_ex}, 64'd7);

        mul("seq_mul", 16'd5, 16'd6, 5'd10, 1'b1);
        single("seq_add", 4'b0000, 16'd1, 16'd1, 16'd0, 5'd11, 1'b1);
        single("seq_shr", 4'b0111, 16'h8000, 16'd15, 16'd0, 5'd12, 1'b1);
        chk("seq_shr_value", {48'd0, result_ex}, 64'h0001);
        gap("gap");

        for (int n = 0; n < 60; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                gap("rnd_gap");
            end else if (r == 1) begin
                mul("rnd_mul", 16'($urandom), 16'($urandom), 5'($urandom), 1'($urandom));
            end else begin
                single("rnd_op", ops[$urandom_range(0, 11)], 16'($urandom), 16'($urandom),
                       16'($urandom), 5'($urandom), 1'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
# execute_stage

Execute (EX) stage of the 16-bit pipelined core, between Instruction Decode and MemoryAccess. Takes decoded operands and the 4-bit control word from decode and evaluates single-cycle ALU ops, load/store address generation, and a 16-cycle iterative multiply. Registers everything MemoryAccess consumes: `control_ex`, `result_ex`, `reg_data_ex`, `dest_reg_index_ex`, `dest_reg_write_en_ex`. Drives `stall_ex` back to decode while a multiply is in flight.

## Interface
Parameters:
- `WIDTH`, 16: datapath width.
- `MUL_CYCLES`, 16: multiply iterations; equals `WIDTH`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `valid_id` in 1: decode presents an instruction this cycle.
- `control_id` in 4: opcode.
- `operand_a_id` in 16: source A / base address.
- `operand_b_id` in 16: source B / offset / shift amount.
- `reg_data_id` in 16: store data, passed through.
- `dest_reg_index_id` in 5: destination register.
- `dest_reg_write_en_id` in 1: destination write enable.
- `control_ex` out 4: registered opcode to MemoryAccess.
- `result_ex` out 16: registered ALU result / memory address.
- `reg_data_ex` out 16: registered store data.
- `dest_reg_index_ex` out 5: registered destination.
- `dest_reg_write_en_ex` out 1: registered write enable.
- `stall_ex` out 1: combinational; decode holds its outputs while high.

## Operation
- Opcodes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, NOT 0101 (~A), SHL 0110, SHR 0111 (logical), MUL 1000, LOAD 1100, STORE 1110, NOP 1111. Other codes are treated as NOP.
- Arithmetic is modulo 2^16. SUB = A + ~B + 1. Shift amount = B[3:0]. MUL keeps only the low 16 bits of A*B.
- LOAD/STORE: `result_ex` = A + B (address). `reg_data_ex` = `reg_data_id`. STORE forces `dest_reg_write_en_ex` = 0.
- Bubble: `control_ex` = NOP, `dest_reg_write_en_ex` = 0, `result_ex`/`reg_data_ex`/`dest_reg_index_ex` = 0.
- FSM IDLE / BUSY:
  - IDLE with `valid_id` and a non-MUL op: register the result at the edge and stay IDLE.
  - IDLE with `valid_id` and MUL: latch A, B, dest index/enable; set count = 0; go to BUSY; output a bubble.
  - IDLE with `valid_id` = 0: output a bubble.
  - BUSY: perform one shift-add step per cycle and output a bubble. When count = MUL_CYCLES-1, register the product with control MUL and return to IDLE. Otherwise increment count.
- `stall_ex` = (IDLE & `valid_id` & MUL) | (BUSY & count != MUL_CYCLES-1).
- Inputs arriving while in BUSY are ignored. Decode is holding the same MUL on its outputs during that time.

## Timing
- Reset: all outputs take bubble values; state = IDLE; count = 0; `stall_ex` = 0 the cycle after reset is sampled.
- Single-cycle op presented in cycle N: outputs valid in cycle N+1. Back-to-back issue runs at 1 op/cycle with no bubbles.
- MUL presented in cycle 0:
  - `stall_ex` is high in cycles 0..15 and low in cycle 16; decode advances at the edge ending cycle 16.
  - Bubbles appear on the outputs in cycles 1..16. The product is on the outputs in cycle 17.
  - An instruction presented in cycle 17 produces its result in cycle 18.
- Reset mid-multiply: the partial product is discarded; IDLE, bubble outputs, and `stall_ex` = 0 follow in the next cycle.
- `reset` takes priority over `valid_id` in the same cycle.

## Structure
- Package `core_pkg`: opcode localparams (shared with decode and MemoryAccess), the `WIDTH` default, and the FSM state encoding.
- Sub-module `seq_multiplier`:
  - Inputs: `start`, A, B.
  - Outputs: `done` pulse, product low word.
  - Contains the shift-add registers and the count.
- The ALU case statement, FSM, and output register live in `execute_stage`.

## Test plan
- ADD A=0xFFFF B=0x0002 in cycle 0 -> cycle 1: `result_ex` = 0x0001, `control_ex` = 0000, `stall_ex` stays 0.
- LOAD A=10 B=2, `reg_data_id` = 13, dest 5, wen 1 -> `result_ex` = 12, `reg_data_ex` = 13, `control_ex` = 1100, dest 5, wen 1. STORE with the same inputs -> wen 0.
- MUL 300*7 in cycle 0, held while stalled:
  - `stall_ex` high for cycles 0..15, low in cycle 16.
  - Bubbles in cycles 1..16.
  - Cycle 17: `result_ex` = 0x0834, `control_ex` = 1000.
- MUL 0x0100*0x0100 -> `result_ex` = 0x0000 (wrap). MUL 0xFFFF*0xFFFF -> 0x0001.
- Reset asserted in BUSY cycle 5 -> next cycle: bubble outputs, `stall_ex` = 0; a following ADD 3+4 yields 7 one cycle later.
- Sequence MUL 5*6 then ADD 1+1 then SHR 0x8000 by 15:
  - Results 30 in cycle 17, 2 in cycle 18, 0x0001 in cycle 19.
  - `valid_id` = 0 gap -> NOP bubble, wen 0.
